// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM state encoding
// and the sizing helper for the bit counter.
package serial_arith_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - borrow_in.
// This is the single arithmetic cell that the serial datapath reuses on every bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~a & borrow_in) | (b & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with valid/ready on both sides.
// One full-subtractor cell and a borrow flop; the result is published on entering DONE.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             busy
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             bit_diff, bit_borrow;
    logic             accept;

    full_subtractor u_cell (
        .a          (opa_q[0]),
        .b          (opb_q[0]),
        .borrow_in  (br_q),
        .diff       (bit_diff),
        .borrow_out (bit_borrow)
    );

    assign accept = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)        state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE:  if (out_ready)     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    always_comb begin
        cnt_d  = cnt_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        res_d  = res_q;
        br_d   = br_q;
        diff_d = diff_q;
        bout_d = bout_q;
        if (state_q == ST_IDLE && accept) begin
            opa_d = a;
            opb_d = b;
            br_d  = borrow_in;
            res_d = '0;
            cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            opa_d = opa_q >> 1;
            opb_d = opb_q >> 1;
            br_d  = bit_borrow;
            res_d = res_q >> 1;
            res_d[WIDTH-1] = bit_diff;
            cnt_d = cnt_q + CW'(1);
            // Outputs only change here, so they stay stable through DONE and the idle gap.
            if (cnt_q == LAST) begin
                diff_d = res_d;
                bout_d = bit_borrow;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            res_q  <= res_d;
            br_q   <= br_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end

    assign difference = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases, backpressure,
// mid-operation reset and a randomized run against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;   // edges from accept (counted as 1) to out_valid

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] difference;
    logic             borrow_out;
    logic             busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
    } vec_t;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .difference (difference),
        .borrow_out (borrow_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic bin);
        return {1'b0, x} - {1'b0, y} - (WIDTH+1)'(bin);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand set from IDLE and waits (bounded) for out_valid.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic bin, output int lat, output bit shift_ok);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        borrow_in = bin;
        tick();
        in_valid  = 1'b0;
        a         = ~x;
        b         = ~y;
        borrow_in = ~bin;
        lat       = 1;
        shift_ok  = 1'b1;
        while (!out_valid && lat < 40) begin
            if (!busy || in_ready) shift_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        tick();
        tick();
        total++;
        if ({in_ready, out_valid, busy, borrow_out, difference} !== {4'b1000, 8'h00}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b bo=%b diff=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, borrow_out, difference);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        vec_t          vecs[5];
        logic [WIDTH:0] exp;
        int            lat;
        bit            shift_ok;
        vecs = '{'{8'h5A, 8'h3C, 1'b0}, '{8'h00, 8'h01, 1'b0}, '{8'h10, 8'h0F, 1'b1},
                 '{8'h00, 8'hFF, 1'b1}, '{8'hFF, 8'hFF, 1'b0}};
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            exp = ref_sub(vecs[i].a, vecs[i].b, vecs[i].bin);
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, shift_ok);
            total++;
            if (lat !== LAT) begin
                bad++;
                $display("FAIL latency[%0d]: got %0d edges, want %0d", i, lat, LAT);
            end
            total++;
            if ({borrow_out, difference} !== exp) begin
                bad++;
                $display("FAIL result[%0d]: %h-%h-%b got bo=%b diff=%h, want bo=%b diff=%h",
                         i, vecs[i].a, vecs[i].b, vecs[i].bin, borrow_out, difference, exp[WIDTH], exp[WIDTH-1:0]);
            end
            total++;
            if (!shift_ok) begin
                bad++;
                $display("FAIL shift_flags[%0d]: busy/in_ready wrong during SHIFT, want busy=1 in_ready=0", i);
            end
            tick();
            total++;
            if ({out_valid, in_ready, busy} !== 3'b010 || {borrow_out, difference} !== exp) begin
                bad++;
                $display("FAIL single_done[%0d]: got vld=%b rdy=%b busy=%b bo=%b diff=%h, want 0 1 0 held %h",
                         i, out_valid, in_ready, busy, borrow_out, difference, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH:0] exp;
        int             lat;
        bit             shift_ok;
        exp       = ref_sub(8'hC3, 8'h35, 1'b0);
        out_ready = 1'b0;
        run_op(8'hC3, 8'h35, 1'b0, lat, shift_ok);
        for (int i = 0; i < 5; i++) begin
            in_valid  = i[0];
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            borrow_in = 1'b1;
            tick();
            total++;
            if ({out_valid, in_ready} !== 2'b10 || {borrow_out, difference} !== exp) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b bo=%b diff=%h, want 1 0 %h",
                         i, out_valid, in_ready, borrow_out, difference, exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b busy=%b, want 0 1 0",
                     out_valid, in_ready, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_in_valid: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH:0] exp;
        int             lat;
        bit             shift_ok;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'h77;
        b         = 8'h12;
        borrow_in = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, busy, borrow_out, difference} !== {4'b1000, 8'h00}) begin
            bad++;
            $display("FAIL async_reset: got rdy=%b vld=%b busy=%b bo=%b diff=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, borrow_out, difference);
        end
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: got vld=%b busy=%b, want 0 0", out_valid, busy);
        end
        exp = ref_sub(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, lat, shift_ok);
        total++;
        if ({borrow_out, difference} !== exp || lat !== LAT) begin
            bad++;
            $display("FAIL after_reset_op: got bo=%b diff=%h lat=%0d, want bo=%b diff=%h lat=%0d",
                     borrow_out, difference, lat, exp[WIDTH], exp[WIDTH-1:0], LAT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] expq[$];
        logic [WIDTH:0] exp;
        int             done   = 0;
        int             cycles = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (done < 1000 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            borrow_in = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) expq.push_back(ref_sub(a, b, borrow_in));
            if (out_valid && out_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL random_spurious: out_valid with nothing outstanding, diff=%h", difference);
                end else begin
                    exp = expq.pop_front();
                    if ({borrow_out, difference} !== exp) begin
                        bad++;
                        $display("FAIL random_op[%0d]: got bo=%b diff=%h, want bo=%b diff=%h",
                                 done, borrow_out, difference, exp[WIDTH], exp[WIDTH-1:0]);
                    end
                end
                done++;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        total++;
        if (done != 1000) begin
            bad++;
            $display("FAIL random_timeout: completed %0d ops, want 1000", done);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
